// File: rtl/instruction_prefetch_stage_if.sv
// Cache-side and decode-side signals of the instruction prefetch stage.
// The prefetch stage takes the master modport; the cache/decode environment takes slave.
interface instruction_prefetch_stage_if #(
  parameter int ADDR_WIDTH  = 30,
  parameter int INSTR_WIDTH = 30,
  parameter int DEPTH       = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDR_WIDTH-1:0]  cache_address_o;
  logic [INSTR_WIDTH-1:0] cache_data_i;
  logic                   cache_blocking_n_i;
  logic                   stall_i;
  logic                   branching;
  logic [ADDR_WIDTH:0]    branch_pc;
  logic [INSTR_WIDTH-1:0] instr_o;
  logic [ADDR_WIDTH-1:0]  pc_o;
  logic                   instr_valid_o;
  logic                   ins_busywait_o;
  logic                   misaligned_o;
  logic [CW-1:0]          count_o;

  modport master (
    output cache_address_o,
    input  cache_data_i,
    input  cache_blocking_n_i,
    input  stall_i,
    input  branching,
    input  branch_pc,
    output instr_o,
    output pc_o,
    output instr_valid_o,
    output ins_busywait_o,
    output misaligned_o,
    output count_o
  );

  modport slave (
    input  cache_address_o,
    output cache_data_i,
    output cache_blocking_n_i,
    output stall_i,
    output branching,
    output branch_pc,
    input  instr_o,
    input  pc_o,
    input  instr_valid_o,
    input  ins_busywait_o,
    input  misaligned_o,
    input  count_o
  );
endinterface

// File: rtl/instruction_prefetch_stage.sv
// Instruction fetch stage: sequential cache fetch into a DEPTH-entry {pc, instr}
// FIFO, one issue per unstalled cycle to decode, flush on branch redirect.
module instruction_prefetch_stage #(
  parameter int                     ADDR_WIDTH  = 30,
  parameter int                     INSTR_WIDTH = 30,
  parameter int                     DEPTH       = 4,
  parameter logic [INSTR_WIDTH-1:0] INSTR_NOP   = 30'b000000000000000000000000000100
) (
  input logic                            clk_i,
  input logic                            rst_i,
  instruction_prefetch_stage_if.master   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] instr;
  } entry_t;

  entry_t                 mem_q [DEPTH];
  logic [PW-1:0]          head_q, head_d;
  logic [PW-1:0]          tail_q, tail_d;
  logic [CW-1:0]          count_q, count_d;
  logic [ADDR_WIDTH-1:0]  fetch_q, fetch_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic                   valid_q, valid_d;
  logic                   mis_q, mis_d;
  logic                   push, pop;
  entry_t                 head_entry;

  assign head_entry = mem_q[head_q];

  always_comb begin
    pop     = 1'b0;
    push    = 1'b0;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    fetch_d = fetch_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    mis_d   = 1'b0;

    if (bus.branching) begin
      // Redirect: drop everything queued and restart at the truncated word target.
      fetch_d = bus.branch_pc[ADDR_WIDTH:1];
      mis_d   = bus.branch_pc[0];
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      instr_d = INSTR_NOP;
      valid_d = 1'b0;
    end else begin
      pop  = !bus.stall_i && (count_q != '0);
      push = bus.cache_blocking_n_i && ((count_q < CW'(DEPTH)) || pop);

      if (push) begin
        tail_d  = tail_q + PW'(1);
        fetch_d = fetch_q + ADDR_WIDTH'(1);
      end

      if (pop) begin
        head_d  = head_q + PW'(1);
        instr_d = head_entry.instr;
        pc_d    = head_entry.pc;
        valid_d = 1'b1;
      end else if (!bus.stall_i) begin
        instr_d = INSTR_NOP;
        valid_d = 1'b0;
      end

      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      fetch_q <= '0;
      instr_q <= INSTR_NOP;
      pc_q    <= '0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      fetch_q <= fetch_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
    end
  end

  // Storage holds data only; occupancy is tracked by the pointers, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      mem_q[tail_q] <= '{pc: fetch_q, instr: bus.cache_data_i};
    end
  end

  assign bus.cache_address_o = fetch_q;
  assign bus.instr_o         = instr_q;
  assign bus.pc_o            = pc_q;
  assign bus.instr_valid_o   = valid_q;
  assign bus.misaligned_o    = mis_q;
  assign bus.count_o         = count_q;
  assign bus.ins_busywait_o  = (count_q == '0);

endmodule

// File: tb/tb_instruction_prefetch_stage.sv
// Directed vector bench for instruction_prefetch_stage; the cache model returns 0x100+address.
module tb_instruction_prefetch_stage;
  localparam int AW = 30;
  localparam int IW = 30;
  localparam int DEPTH = 4;
  localparam logic [IW-1:0] NOP = 30'h4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  instruction_prefetch_stage_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(DEPTH)) bus ();

  instruction_prefetch_stage #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  always_comb bus.cache_data_i = IW'(32'h100 + 32'(bus.cache_address_o));

  typedef struct {
    logic          rst, blk, st, br;
    logic [AW:0]   bpc;
    logic [AW-1:0] addr;
    logic [IW-1:0] instr;
    logic [AW-1:0] pc;
    logic          vld;
    logic [2:0]    cnt;
    logic          mis;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic r, logic b, logic s, logic br, logic [AW:0] bpc,
                              logic [AW-1:0] a, logic [IW-1:0] i, logic [AW-1:0] p,
                              logic v, logic [2:0] c, logic m);
    vec_t t;
    t.rst = r; t.blk = b; t.st = s; t.br = br; t.bpc = bpc;
    t.addr = a; t.instr = i; t.pc = p; t.vld = v; t.cnt = c; t.mis = m;
    vecs.push_back(t);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step(logic r, logic b, logic s, logic br, logic [AW:0] bpc);
    @(negedge clk);
    rst = r;
    bus.cache_blocking_n_i = b;
    bus.stall_i = s;
    bus.branching = br;
    bus.branch_pc = bpc;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(string tag, logic [AW-1:0] a, logic [IW-1:0] i, logic [AW-1:0] p,
                           logic v, logic [2:0] c, logic m);
    check({tag, " addr"},  32'(bus.cache_address_o), 32'(a));
    check({tag, " instr"}, 32'(bus.instr_o), 32'(i));
    check({tag, " pc"},    32'(bus.pc_o), 32'(p));
    check({tag, " valid"}, 32'(bus.instr_valid_o), 32'(v));
    check({tag, " count"}, 32'(bus.count_o), 32'(c));
    check({tag, " mis"},   32'(bus.misaligned_o), 32'(m));
    check({tag, " busy"},  32'(bus.ins_busywait_o), 32'(c == 3'd0));
  endtask

  initial begin
    bus.cache_blocking_n_i = 1'b0;
    bus.stall_i = 1'b0;
    bus.branching = 1'b0;
    bus.branch_pc = '0;

    // Streaming after reset
    add(1,1,0,0,0,     0, NOP,     0, 0, 0, 0);
    add(0,1,0,0,0,     1, NOP,     0, 0, 1, 0);
    add(0,1,0,0,0,     2, 'h100,   0, 1, 1, 0);
    add(0,1,0,0,0,     3, 'h101,   1, 1, 1, 0);
    add(0,1,0,0,0,     4, 'h102,   2, 1, 1, 0);
    // Stall fills the queue, release drains in order with push+pop at full
    add(1,1,0,0,0,     0, NOP,     0, 0, 0, 0);
    add(0,1,1,0,0,     1, NOP,     0, 0, 1, 0);
    add(0,1,1,0,0,     2, NOP,     0, 0, 2, 0);
    add(0,1,1,0,0,     3, NOP,     0, 0, 3, 0);
    add(0,1,1,0,0,     4, NOP,     0, 0, 4, 0);
    for (int k = 0; k < 6; k++) add(0,1,1,0,0, 4, NOP, 0, 0, 4, 0);
    add(0,1,0,0,0,     5, 'h100,   0, 1, 4, 0);
    add(0,1,0,0,0,     6, 'h101,   1, 1, 4, 0);
    add(0,1,0,0,0,     7, 'h102,   2, 1, 4, 0);
    add(0,1,0,0,0,     8, 'h103,   3, 1, 4, 0);
    add(0,1,0,0,0,     9, 'h104,   4, 1, 4, 0);
    // Branch at count 3 flushes
    add(1,1,0,0,0,     0, NOP,     0, 0, 0, 0);
    add(0,1,1,0,0,     1, NOP,     0, 0, 1, 0);
    add(0,1,1,0,0,     2, NOP,     0, 0, 2, 0);
    add(0,1,1,0,0,     3, NOP,     0, 0, 3, 0);
    add(0,1,0,1,'h40,  'h20, NOP,  0, 0, 0, 0);
    add(0,1,0,0,0,     'h21, NOP,  0, 0, 1, 0);
    add(0,1,0,0,0,     'h22, 'h120, 'h20, 1, 1, 0);
    add(0,1,0,0,0,     'h23, 'h121, 'h21, 1, 1, 0);
    // Misaligned target
    add(0,1,0,1,'h43,  'h21, NOP,  'h21, 0, 0, 1);
    add(0,1,0,0,0,     'h22, NOP,  'h21, 0, 1, 0);
    add(0,1,0,0,0,     'h23, 'h121, 'h21, 1, 1, 0);
    // Branch while stalled and cache blocked
    add(0,0,1,1,'h80,  'h40, NOP,  'h21, 0, 0, 0);
    add(0,1,0,0,0,     'h41, NOP,  'h21, 0, 1, 0);
    add(0,1,0,0,0,     'h42, 'h140, 'h40, 1, 1, 0);
    // Address wrap
    add(0,1,0,1,31'h7FFFFFFC, 30'h3FFFFFFE, NOP, 'h40, 0, 0, 0);
    add(0,1,0,0,0,     30'h3FFFFFFF, NOP, 'h40, 0, 1, 0);
    add(0,1,0,0,0,     0, 'hFE,  30'h3FFFFFFE, 1, 1, 0);
    add(0,1,0,0,0,     1, 'hFF,  30'h3FFFFFFF, 1, 1, 0);
    add(0,1,0,0,0,     2, 'h100, 0, 1, 1, 0);
    // Mid-stream reset, then blocked cache while empty
    add(1,1,0,0,0,     0, NOP,     0, 0, 0, 0);
    add(0,0,0,0,0,     0, NOP,     0, 0, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].blk, vecs[i].st, vecs[i].br, vecs[i].bpc);
      check_all($sformatf("v%0d", i), vecs[i].addr, vecs[i].instr, vecs[i].pc,
                vecs[i].vld, vecs[i].cnt, vecs[i].mis);
    end

    // Full queue with cache ready but stalled: address must stay put
    for (int k = 0; k < 4; k++) step(0,1,1,0,0);
    check_all("fill", 4, NOP, 0, 0, 4, 0);
    step(0,1,1,0,0);
    step(0,1,1,0,0);
    check_all("hold_full", 4, NOP, 0, 0, 4, 0);

    // Reset wins over a simultaneous misaligned branch
    step(1,1,0,1,'h43);
    check_all("rst_br", 0, NOP, 0, 0, 0, 0);
    step(0,0,0,0,0);
    check_all("idle", 0, NOP, 0, 0, 0, 0);

    // Stalled with valid output: branch still clears valid and redirects
    step(0,1,0,0,0);
    step(0,1,0,0,0);
    check_all("pre_st", 2, 'h100, 0, 1, 1, 0);
    step(0,1,1,0,0);
    check_all("st_hold", 3, 'h100, 0, 1, 2, 0);
    step(0,1,1,1,'h21);
    check_all("st_br", 'h10, NOP, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instruction_prefetch_stage.md
Name: instruction_prefetch_stage

Overview:
Parametrised instruction fetch stage that decouples cache fetch from decode through a FIFO prefetch buffer. Fetches sequential words from the instruction cache into a DEPTH-entry queue of {pc, instr}, and issues one entry per unstalled cycle to decode. A branch redirect flushes the queue. It sits between the instruction cache and the decode stage and exposes occupancy and misaligned-target status.

Parameters:
ADDR_WIDTH, 30, word-address width (PC bits [31:2]).
INSTR_WIDTH, 30, stored instruction width (instruction bits [31:2]).
DEPTH, 4, prefetch FIFO entries; power of two, >= 2.
INSTR_NOP, 30'b000000000000000000000000000100, word issued when nothing valid.

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-high
cache_address_o  out  ADDR_WIDTH  word address being fetched (= fetch counter)
cache_data_i  in  INSTR_WIDTH  word at cache_address_o, same cycle
cache_blocking_n_i  in  1  1 = cache_data_i valid this cycle
stall_i  in  1  decode stall; hold outputs, no pop
branching  in  1  redirect request this cycle
branch_pc  in  31  redirect target, bits [31:1]
instr_o  out  INSTR_WIDTH  issued instruction, registered
pc_o  out  ADDR_WIDTH  word PC of instr_o, registered
instr_valid_o  out  1  instr_o came from the FIFO (0 = NOP bubble)
ins_busywait_o  out  1  combinational; 1 when FIFO empty
misaligned_o  out  1  one-cycle pulse; accepted branch had branch_pc[1]=1
count_o  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH

Behaviour:
- Reset (rst_i=1 at edge): fetch counter=0, FIFO empty (count_o=0), instr_o=INSTR_NOP, pc_o=0, instr_valid_o=0, misaligned_o=0. Reset overrides every other input, including mid-fetch and mid-branch.
- Priority per edge: reset > branching > normal fetch/issue.
- Branch (branching=1): fetch counter<=branch_pc[31:2]. FIFO flushed to count 0. Any push or pop this cycle is suppressed. instr_o<=INSTR_NOP, instr_valid_o<=0, pc_o held. Branch is accepted regardless of stall_i and cache_blocking_n_i.
- Misaligned target: misaligned_o<=branch_pc[1] on the accepting edge, else 0. The target is truncated to the word address; no other effect.
- Push: when !branching, cache_blocking_n_i=1, and (count<DEPTH or pop this cycle), write {fetch counter, cache_data_i} at the tail and advance the fetch counter by 1. The counter wraps from 2^ADDR_WIDTH-1 to 0 with no flag.
- No push when full without a simultaneous pop, or when cache_blocking_n_i=0. In both cases the counter holds and cache_address_o is stable.
- Pop: when !branching, !stall_i and count>0: instr_o/pc_o<=head entry, instr_valid_o<=1.
- Empty and unstalled: instr_o<=INSTR_NOP, instr_valid_o<=0, pc_o held.
- stall_i=1 (no branch): instr_o, pc_o and instr_valid_o hold. Fetch continues until the FIFO is full.
- Simultaneous push and pop: allowed; count unchanged, including at full (DEPTH). There is no empty bypass: a pushed word is issuable the next cycle at the earliest.
- Latency: from the cycle address A is presented with cache_blocking_n_i=1, instr_o for A appears 2 edges later if unstalled.
- Head/tail pointers are $clog2(DEPTH) bits and wrap naturally. count_o = pushes − pops.

Test Plan:
- Reset then cache_blocking_n_i=1, stall_i=0, cache returns 0x100+addr: cache_address_o 0,1,2,...; instr_o NOP for 2 edges, then 0x100,0x101,... with pc_o 0,1,...; instr_valid_o=1 from edge 2.
- stall_i=1 for 10 cycles after reset, DEPTH=4: cache_address_o stops at 4; count_o=4; instr_o held. Release stall: 4 queued words issue in order and fetch resumes at address 4 without gaps.
- At count_o=3 pulse branching with branch_pc=0x40 (word 0x20): next edge count_o=0, instr_o=NOP, cache_address_o=0x20. Then 0x20,0x21 issue; no pre-branch entries are issued.
- branch_pc[1]=1, branch_pc=0x43: misaligned_o pulses 1 cycle; fetch restarts at word 0x21.
- Branch with stall_i=1 and cache_blocking_n_i=0 simultaneously: branch still taken, FIFO flushed, and the new address is presented next cycle.
- Preload the counter to 2^ADDR_WIDTH−2 via branch: addresses wrap ...FFE, ...FFF, 0; full queue with push+pop each cycle keeps count_o=DEPTH; rst_i asserted mid-stream clears everything to the reset values.
